npu_weight_fetch_ctrl: RTL and testbench

//  Sequences reads from the 32-lane weights ROM (shared address, DATA_WIDTH per lane) and

---
 rtl/npu_weight_fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_npu_weight_fetch_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_weight_fetch_ctrl.sv
// Weight-ROM row fetch sequencer: issues row reads, absorbs ROM latency in a credit-limited
// output FIFO and streams rows to the MAC array. Optional stall counter: NPU_WFETCH_STALL_CNT_EN.
`ifndef LOG2_FILTER_MEM_ADDR_WIDTH
`define LOG2_FILTER_MEM_ADDR_WIDTH 10
`endif

module npu_weight_fetch_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEN_WIDTH   = 12
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [`LOG2_FILTER_MEM_ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]                   cmd_len,
  input  logic                                   flush,
  output logic [`LOG2_FILTER_MEM_ADDR_WIDTH-1:0] rom_rd_addr,
  input  logic [32*DATA_WIDTH-1:0]               rom_rd_data,
  output logic [32*DATA_WIDTH-1:0]               weights_data,
  output logic                                   weights_valid,
  input  logic                                   weights_ready,
  output logic                                   weights_last,
  output logic                                   busy,
  output logic                                   done,
  output logic [31:0]                            stall_cnt
);

  localparam int ROW_W = 32 * DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                 state_reg, state_next;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [LEN_WIDTH-1:0]   issued_reg;
  logic [LEN_WIDTH-1:0]   push_idx_reg;
  logic [ROM_LATENCY:0]   pipe_reg;
  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]       fifo_count_reg;
  logic [ROW_W:0]         fifo_mem [FIFO_DEPTH];
  logic [ROW_W:0]         fifo_head;

  logic       accept, issue, push, pop, credit_ok;
  logic [7:0] inflight, occupancy;

  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign accept    = cmd_valid & cmd_ready & ~flush;
  assign push      = pipe_reg[ROM_LATENCY];
  assign pop       = weights_valid & weights_ready;

  // A row popped this cycle frees its slot before the newly issued read can land.
  assign inflight  = 8'($countones(pipe_reg));
  assign occupancy = 8'(fifo_count_reg) + inflight - 8'(pop);
  assign credit_ok = occupancy < 8'(FIFO_DEPTH);

  assign fifo_head     = fifo_mem[rd_ptr_reg];
  assign weights_valid = (fifo_count_reg != '0);
  assign weights_data  = weights_valid ? fifo_head[ROW_W-1:0] : '0;
  assign weights_last  = weights_valid & fifo_head[ROW_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          // First read goes out with acceptance so the address is valid the next cycle.
          issue      = (cmd_len != '0);
          state_next = (cmd_len != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        if (issued_reg == len_reg) state_next = S_DRAIN;
        else                       issue = ~flush & credit_ok;
      end
      S_DRAIN: begin
        if (inflight == 8'd0 &&
            (fifo_count_reg == '0 || (fifo_count_reg == CNT_W'(1) && pop)))
          state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_rd_addr    <= '0;
      len_reg        <= '0;
      issued_reg     <= '0;
      push_idx_reg   <= '0;
      pipe_reg       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else if (flush) begin
      issued_reg     <= '0;
      push_idx_reg   <= '0;
      pipe_reg       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (accept) begin
        len_reg      <= cmd_len;
        issued_reg   <= (cmd_len != '0) ? LEN_WIDTH'(1) : '0;
        push_idx_reg <= '0;
      end else if (issue) begin
        issued_reg <= issued_reg + LEN_WIDTH'(1);
      end
      // Consecutive rows, so incrementing equals base+issued and wraps at the top row.
      if (issue)
        rom_rd_addr <= (state_reg == S_IDLE) ? cmd_base : rom_rd_addr + 1'b1;
      pipe_reg <= {pipe_reg[ROM_LATENCY-1:0], issue};
      if (push) begin
        wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
        push_idx_reg <= push_idx_reg + LEN_WIDTH'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= {(push_idx_reg == len_reg - LEN_WIDTH'(1)), rom_rd_data};
  end

`ifdef NPU_WFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_reg <= '0;
    else if (accept)
      stall_cnt_reg <= '0;
    else if (weights_valid && !weights_ready && stall_cnt_reg != 32'hFFFF_FFFF)
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_npu_weight_fetch_ctrl.sv
// Scoreboard bench for npu_weight_fetch_ctrl: stimulus queues expected rows, a negedge
// monitor pops and compares each transferred row; ROM modelled with 2-cycle latency.
`ifndef LOG2_FILTER_MEM_ADDR_WIDTH
`define LOG2_FILTER_MEM_ADDR_WIDTH 10
`endif

module tb_npu_weight_fetch_ctrl;
  localparam int AW   = `LOG2_FILTER_MEM_ADDR_WIDTH;
  localparam int ROWW = 512;
  localparam int MAXA = (1 << AW) - 1;

  typedef struct {
    logic            last;
    logic [ROWW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_base = '0;
  logic [11:0]     cmd_len = '0;
  logic            flush = 1'b0;
  logic [AW-1:0]   rom_rd_addr;
  logic [ROWW-1:0] rom_rd_data;
  logic [ROWW-1:0] weights_data;
  logic            weights_valid;
  logic            weights_ready = 1'b1;
  logic            weights_last;
  logic            busy;
  logic            done;
  logic [31:0]     stall_cnt;

  npu_weight_fetch_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .flush(flush), .rom_rd_addr(rom_rd_addr),
    .rom_rd_data(rom_rd_data), .weights_data(weights_data), .weights_valid(weights_valid),
    .weights_ready(weights_ready), .weights_last(weights_last), .busy(busy), .done(done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int accept_cyc = 0;
  int cmd_xfers = 0;
  exp_t exp_q[$];
  exp_t e;

  // ROM model: two registered stages between address and data.
  logic [AW-1:0] rom_a1, rom_a2;
  always @(posedge clk) begin
    rom_a1 <= rom_rd_addr;
    rom_a2 <= rom_a1;
    cyc    <= cyc + 1;
  end

  function automatic logic [ROWW-1:0] rom_row(input logic [AW-1:0] addr);
    logic [ROWW-1:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i*16 +: 16] = 16'({6'(i), 10'(addr)}) ^ 16'h5A00;
    return r;
  endfunction

  assign rom_rd_data = rom_row(rom_a2);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (weights_valid && weights_ready) begin
        if (cmd_xfers == 0) first_cyc = cyc;
        cmd_xfers++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_row: got row while scoreboard empty, expected none");
        end else begin
          e = exp_q.pop_front();
          if (weights_data !== e.data) begin
            n_fail++;
            $display("FAIL row_data: got %0h expected %0h", weights_data, e.data);
          end
          n_checks++;
          if (weights_last !== e.last) begin
            n_fail++;
            $display("FAIL row_last: got %0b expected %0b", weights_last, e.last);
          end
        end
        if (weights_last) last_cyc = cyc;
        $display("row %0d @cyc %0d last=%0b", cmd_xfers, cyc, weights_last);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] base, input logic [11:0] len);
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    check("cmd_ready", cmd_ready, 1);
    for (int k = 0; k < int'(len); k++)
      exp_q.push_back('{last: (k == int'(len) - 1), data: rom_row(base + AW'(k))});
    cmd_xfers  = 0;
    accept_cyc = cyc;
    $display("cmd base=%0h len=%0d @cyc %0d", base, len, cyc);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start;
    start = done_count;
    for (int i = 0; i < 300 && done_count == start; i++) step();
    check(name, done_count - start, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int dstart;
    logic [31:0] exp_stall;

    // Reset values
    repeat (3) step();
    rst = 1'b0;
    check("rst_valid", weights_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rom_rd_addr, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_data", weights_data[63:0], 0);
    step();
    check("rst_cmd_ready", cmd_ready, 1);

    // Stream: consecutive addresses, 4-cycle latency, done right after last
    weights_ready = 1'b1;
    dstart = done_count;
    send_cmd(AW'(12'h010), 12'd8);
    for (int k = 0; k < 8; k++) begin
      check("stream_addr", rom_rd_addr, 64'h010 + 64'(k));
      step();
    end
    wait_done("stream_done");
    check("stream_first_lat", first_cyc - accept_cyc, 4);
    check("stream_last_cyc", last_cyc - accept_cyc, 11);
    check("stream_done_cyc", done_cyc - last_cyc, 1);
    check("stream_count", cmd_xfers, 8);
    check("stream_sb_empty", exp_q.size(), 0);
    check("stream_stall", stall_cnt, 0);
    step();
    check("stream_one_done", done_count - dstart, 1);

    // Backpressure: 10 stalled cycles once valid, then alternate ready
    weights_ready = 1'b0;
    send_cmd(AW'(12'h100), 12'd16);
    repeat (13) step();
    for (int i = 0; i < 31; i++) begin
      weights_ready = (i % 2 == 0);
      step();
    end
    weights_ready = 1'b1;
    wait_done("bp_done");
    check("bp_count", cmd_xfers, 16);
    check("bp_sb_empty", exp_q.size(), 0);
`ifdef NPU_WFETCH_STALL_CNT_EN
    exp_stall = 32'd25;
`else
    exp_stall = 32'd0;
`endif
    check("bp_stall", stall_cnt, exp_stall);

    // Address wrap past the top row
    send_cmd(AW'(MAXA - 1), 12'd4);
    check("wrap_addr0", rom_rd_addr, 64'(MAXA - 1));
    step();
    check("wrap_addr1", rom_rd_addr, 64'(MAXA));
    step();
    check("wrap_addr2", rom_rd_addr, 0);
    step();
    check("wrap_addr3", rom_rd_addr, 1);
    wait_done("wrap_done");
    check("wrap_count", cmd_xfers, 4);

    // Zero length
    dstart = done_count;
    send_cmd(AW'(12'h055), 12'd0);
    check("zero_done_pulse", done, 1);
    check("zero_valid", weights_valid, 0);
    check("zero_addr", rom_rd_addr, 1);
    step();
    check("zero_done_clear", done, 0);
    check("zero_cmd_ready", cmd_ready, 1);
    repeat (5) step();
    check("zero_one_done", done_count - dstart, 1);
    check("zero_no_rows", cmd_xfers, 0);
    check("zero_addr_hold", rom_rd_addr, 1);

    // Flush after 3 rows consumed
    dstart = done_count;
    send_cmd(AW'(12'h020), 12'd8);
    repeat (6) step();
    check("flush_consumed", cmd_xfers, 3);
    weights_ready = 1'b0;
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    weights_ready = 1'b1;
    check("flush_idle", busy, 0);
    check("flush_valid", weights_valid, 0);
    check("flush_cmd_ready", cmd_ready, 1);
    repeat (8) step();
    check("flush_no_done", done_count - dstart, 0);
    check("flush_no_rows", cmd_xfers, 3);
    send_cmd(AW'(12'h200), 12'd3);
    check("post_flush_addr", rom_rd_addr, 64'h200);
    wait_done("post_flush_done");
    check("post_flush_count", cmd_xfers, 3);

    // Reset mid-stream
    dstart = done_count;
    send_cmd(AW'(12'h080), 12'd8);
    repeat (4) step();
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", weights_valid, 0);
    check("mid_rst_last", weights_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", rom_rd_addr, 0);
    check("mid_rst_stall", stall_cnt, 0);
    step();
    rst = 1'b0;
    step();
    check("mid_rst_cmd_ready", cmd_ready, 1);
    repeat (10) step();
    check("mid_rst_no_done", done_count - dstart, 0);
    check("mid_rst_valid_after", weights_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
